// File: rtl/cache_pkg.sv
// Definitions shared by the dcache blocks: write-type codes, line geometry
// and the state encoding of the write serializer.
package cache_pkg;

    localparam logic [2:0] WR_BYTE = 3'b000;
    localparam logic [2:0] WR_HALF = 3'b001;
    localparam logic [2:0] WR_WORD = 3'b010;
    localparam logic [2:0] WR_LINE = 3'b100;

    localparam int LINE_WORDS = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_SEND = 3'b010,
        S_GAP  = 3'b100
    } wr_state_e;

endpackage

// File: rtl/dcache_wr_serializer.sv
// One-entry write buffer between the dcache and the bridge's single-beat write
// port: line write-backs leave as ascending word beats, stores as one beat.
module dcache_wr_serializer #(
    parameter int LINE_WORDS = cache_pkg::LINE_WORDS
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     c_wr_req,
    input  logic [2:0]               c_wr_type,
    input  logic [31:0]              c_wr_addr,
    input  logic [3:0]               c_wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] c_wr_data,
    output logic                     c_wr_rdy,
    output logic                     b_wr_req,
    output logic [2:0]               b_wr_type,
    output logic [31:0]              b_wr_addr,
    output logic [3:0]               b_wr_wstrb,
    output logic [31:0]              b_wr_data,
    input  logic                     b_wr_rdy,
    input  logic [31:0]              rd_chk_addr,
    output logic                     rd_hazard,
    output logic                     wr_done
);
    import cache_pkg::wr_state_e;
    import cache_pkg::S_IDLE;
    import cache_pkg::S_SEND;
    import cache_pkg::S_GAP;
    import cache_pkg::WR_WORD;
    import cache_pkg::WR_LINE;

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

    wr_state_e                   r_state;
    wr_state_e                   w_next_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [2:0]                  r_type;
    logic [31:0]                 r_addr;
    logic [3:0]                  r_wstrb;
    logic [LINE_WORDS-1:0][31:0] r_data;
    logic                        r_wr_done;

    logic w_capture;
    logic w_beat_fire;
    logic w_is_line;
    logic w_last_beat;
    logic w_buf_hit;
    logic w_cap_hit;

    assign w_is_line   = (r_type == WR_LINE);
    assign w_last_beat = !w_is_line || (r_cnt == LAST_CNT);
    assign w_capture   = c_wr_req & c_wr_rdy;
    assign w_beat_fire = b_wr_req & b_wr_rdy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        w_next_state = r_state;
        c_wr_rdy     = 1'b0;
        b_wr_req     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                c_wr_rdy = 1'b1;
                if (c_wr_req) begin
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                b_wr_req = 1'b1;
                if (b_wr_rdy) begin
                    w_next_state = w_last_beat ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                w_next_state = S_SEND;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: the buffer is reset as well, because the beat outputs are driven
    // straight from it and must read zero out of reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_cnt     <= '0;
            r_type    <= '0;
            r_addr    <= '0;
            r_wstrb   <= '0;
            r_data    <= '0;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= w_beat_fire & w_last_beat;
            if (w_capture) begin
                r_cnt   <= '0;
                r_type  <= c_wr_type;
                r_addr  <= c_wr_addr;
                r_wstrb <= c_wr_wstrb;
                r_data  <= c_wr_data;
            end else if (w_beat_fire && !w_last_beat) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Line beats walk the words in ascending order from word 0; the captured
    // offset of a line request plays no part.
    assign b_wr_type  = w_is_line ? WR_WORD : r_type;
    assign b_wr_addr  = w_is_line ? {r_addr[31:OFF_W], r_cnt, 2'b00} : r_addr;
    assign b_wr_wstrb = w_is_line ? 4'hF : r_wstrb;
    assign b_wr_data  = w_is_line ? r_data[r_cnt] : r_data[0];
    assign wr_done    = r_wr_done;

    assign w_buf_hit = (r_state != S_IDLE) &&
                       (rd_chk_addr[31:OFF_W] == r_addr[31:OFF_W]);
    assign w_cap_hit = w_capture &&
                       (c_wr_addr[31:OFF_W] == rd_chk_addr[31:OFF_W]);
    assign rd_hazard = w_buf_hit | w_cap_hit;

endmodule

// File: tb/tb_dcache_wr_serializer.sv
// Bench for dcache_wr_serializer: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-queue reference model.
module tb_dcache_wr_serializer;
    import cache_pkg::*;

    localparam int LW = 4;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         c_wr_req;
    logic [2:0]   c_wr_type;
    logic [31:0]  c_wr_addr;
    logic [3:0]   c_wr_wstrb;
    logic [127:0] c_wr_data;
    logic         c_wr_rdy;
    logic         b_wr_req;
    logic [2:0]   b_wr_type;
    logic [31:0]  b_wr_addr;
    logic [3:0]   b_wr_wstrb;
    logic [31:0]  b_wr_data;
    logic         b_wr_rdy;
    logic [31:0]  rd_chk_addr;
    logic         rd_hazard;
    logic         wr_done;

    always #5 aclk = ~aclk;

    dcache_wr_serializer #(.LINE_WORDS(LW)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .c_wr_req   (c_wr_req),
        .c_wr_type  (c_wr_type),
        .c_wr_addr  (c_wr_addr),
        .c_wr_wstrb (c_wr_wstrb),
        .c_wr_data  (c_wr_data),
        .c_wr_rdy   (c_wr_rdy),
        .b_wr_req   (b_wr_req),
        .b_wr_type  (b_wr_type),
        .b_wr_addr  (b_wr_addr),
        .b_wr_wstrb (b_wr_wstrb),
        .b_wr_data  (b_wr_data),
        .b_wr_rdy   (b_wr_rdy),
        .rd_chk_addr(rd_chk_addr),
        .rd_hazard  (rd_hazard),
        .wr_done    (wr_done)
    );

    typedef struct {
        logic [2:0]       typ;
        logic [31:0]      addr;
        logic [3:0]       wstrb;
        logic [127:0]     data;
        int               nbeats;
        logic [3:0][31:0] exp_addr;
        logic [3:0][31:0] exp_data;
        logic [3:0]       exp_wstrb;
        logic [2:0]       exp_type;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
        logic [2:0]  typ;
    } beat_t;

    vec_t  vecs[5];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample();
        @(negedge aclk);
    endtask

    task automatic idle_inputs();
        c_wr_req    = 1'b0;
        c_wr_type   = 3'b000;
        c_wr_addr   = 32'h0;
        c_wr_wstrb  = 4'h0;
        c_wr_data   = 128'h0;
        rd_chk_addr = 32'h0;
        b_wr_rdy    = 1'b1;
    endtask

    task automatic drive_req(input logic [2:0] t, input logic [31:0] a,
                             input logic [3:0] s, input logic [127:0] d);
        c_wr_req   = 1'b1;
        c_wr_type  = t;
        c_wr_addr  = a;
        c_wr_wstrb = s;
        c_wr_data  = d;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [2:0] t);
        check({tag, "_req"},   b_wr_req,   1'b1);
        check({tag, "_addr"},  b_wr_addr,  a);
        check({tag, "_data"},  b_wr_data,  d);
        check({tag, "_wstrb"}, b_wr_wstrb, s);
        check({tag, "_type"},  b_wr_type,  t);
    endtask

    task automatic check_gap(input string tag, input logic exp_done);
        check({tag, "_req"},  b_wr_req, 1'b0);
        check({tag, "_done"}, wr_done,  exp_done);
        check({tag, "_rdy"},  c_wr_rdy, exp_done);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive_req(v.typ, v.addr, v.wstrb, v.data);
        sample();
        check({tag, "_cap_rdy"}, c_wr_rdy, 1'b1);
        check({tag, "_cap_req"}, b_wr_req, 1'b0);
        next_cycle();
        c_wr_req  = 1'b0;
        c_wr_data = ~v.data;
        c_wr_addr = ~v.addr;
        for (int c = 1; c <= 2 * v.nbeats; c++) begin
            sample();
            if (c % 2 == 1) begin
                check_beat($sformatf("%s_b%0d", tag, c / 2), v.exp_addr[c / 2],
                           v.exp_data[c / 2], v.exp_wstrb, v.exp_type);
                check($sformatf("%s_b%0d_done", tag, c / 2), wr_done, 1'b0);
            end else begin
                check_gap($sformatf("%s_c%0d", tag, c), c == 2 * v.nbeats);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        next_cycle();
        next_cycle();
        aresetn = 1'b1;
    endtask

    initial begin
        vecs[0] = '{typ: WR_LINE, addr: 32'h1C00_0A38, wstrb: 4'h3,
                    data: 128'h44444444_33333333_22222222_11111111, nbeats: 4,
                    exp_addr: {32'h1C000A3C, 32'h1C000A38, 32'h1C000A34, 32'h1C000A30},
                    exp_data: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    exp_wstrb: 4'hF, exp_type: WR_WORD};
        vecs[1] = '{typ: WR_BYTE, addr: 32'h0000_1003, wstrb: 4'b1000,
                    data: 128'h99999999_88888888_77777777_AB000000, nbeats: 1,
                    exp_addr: {96'h0, 32'h0000_1003}, exp_data: {96'h0, 32'hAB000000},
                    exp_wstrb: 4'b1000, exp_type: WR_BYTE};
        vecs[2] = '{typ: WR_HALF, addr: 32'h0000_2002, wstrb: 4'b1100,
                    data: 128'h1_00000000_00000000_5A5A0000, nbeats: 1,
                    exp_addr: {96'h0, 32'h0000_2002}, exp_data: {96'h0, 32'h5A5A0000},
                    exp_wstrb: 4'b1100, exp_type: WR_HALF};
        vecs[3] = '{typ: WR_WORD, addr: 32'h0000_0030, wstrb: 4'hF,
                    data: 128'hFFFFFFFF_00000000_12345678_CAFEBABE, nbeats: 1,
                    exp_addr: {96'h0, 32'h0000_0030}, exp_data: {96'h0, 32'hCAFEBABE},
                    exp_wstrb: 4'hF, exp_type: WR_WORD};
        vecs[4] = '{typ: WR_LINE, addr: 32'hFFFF_FFF4, wstrb: 4'h0,
                    data: 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, nbeats: 4,
                    exp_addr: {32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF4, 32'hFFFFFFF0},
                    exp_data: {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000},
                    exp_wstrb: 4'hF, exp_type: WR_WORD};

        idle_inputs();
        aresetn = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        check("rst_rdy",    c_wr_rdy,   1'b1);
        check("rst_req",    b_wr_req,   1'b0);
        check("rst_type",   b_wr_type,  3'b000);
        check("rst_addr",   b_wr_addr,  32'h0);
        check("rst_wstrb",  b_wr_wstrb, 4'h0);
        check("rst_data",   b_wr_data,  32'h0);
        check("rst_done",   wr_done,    1'b0);
        check("rst_hazard", rd_hazard,  1'b0);
        next_cycle();
        aresetn = 1'b1;
        next_cycle();

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // Stall: bridge holds rdy low for five cycles on beat 2.
        drive_req(WR_LINE, 32'h0000_3000, 4'h0, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
        next_cycle();
        c_wr_req = 1'b0;
        sample(); check_beat("stall_b0", 32'h3000, 32'hA0A0A0A0, 4'hF, WR_WORD); next_cycle();
        sample(); check_gap("stall_g0", 1'b0); next_cycle();
        sample(); check_beat("stall_b1", 32'h3004, 32'hB1B1B1B1, 4'hF, WR_WORD); next_cycle();
        sample(); check_gap("stall_g1", 1'b0); next_cycle();
        b_wr_rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
            sample();
            check_beat($sformatf("stall_hold%0d", s), 32'h3008, 32'hC2C2C2C2, 4'hF, WR_WORD);
            check($sformatf("stall_hold%0d_done", s), wr_done, 1'b0);
            next_cycle();
        end
        b_wr_rdy = 1'b1;
        sample(); check_beat("stall_b2", 32'h3008, 32'hC2C2C2C2, 4'hF, WR_WORD); next_cycle();
        sample(); check_gap("stall_g2", 1'b0); next_cycle();
        sample(); check_beat("stall_b3", 32'h300C, 32'hD3D3D3D3, 4'hF, WR_WORD); next_cycle();
        sample(); check_gap("stall_end", 1'b1); next_cycle();

        // Hazard window during a drain, plus a request pulse that must be ignored.
        drive_req(WR_LINE, 32'h8000_0040, 4'h0, 128'h0000000D_0000000C_0000000B_0000000A);
        rd_chk_addr = 32'h8000_0048;
        sample(); check("haz_capture", rd_hazard, 1'b1); next_cycle();
        c_wr_req = 1'b0;
        rd_chk_addr = 32'h8000_004C;
        sample(); check("haz_send_hit", rd_hazard, 1'b1);
        check_beat("haz_b0", 32'h80000040, 32'h0000000A, 4'hF, WR_WORD); next_cycle();
        rd_chk_addr = 32'h8000_0050;
        sample(); check("haz_next_line", rd_hazard, 1'b0); next_cycle();
        drive_req(WR_WORD, 32'h1234_0000, 4'hF, {4{32'hFFFF_FFFF}});
        sample(); check("ign_rdy", c_wr_rdy, 1'b0); check("ign_haz", rd_hazard, 1'b0);
        check_beat("haz_b1", 32'h80000044, 32'h0000000B, 4'hF, WR_WORD); next_cycle();
        c_wr_req = 1'b0;
        rd_chk_addr = 32'h8000_004C;
        for (int c = 4; c <= 8; c++) begin
            sample();
            if (c == 5) check_beat("haz_b2", 32'h80000048, 32'h0000000C, 4'hF, WR_WORD);
            if (c == 7) check_beat("haz_b3", 32'h8000004C, 32'h0000000D, 4'hF, WR_WORD);
            check($sformatf("haz_c%0d", c), rd_hazard, c != 8);
            if (c == 8) check("haz_done", wr_done, 1'b1);
            next_cycle();
        end
        sample(); check("ign_no_capture", b_wr_req, 1'b0); check("haz_after", rd_hazard, 1'b0);
        next_cycle();

        // Back-to-back: second request waits from T+1, captured on the wr_done cycle.
        drive_req(WR_LINE, 32'h0000_0400, 4'h0, 128'h00000403_00000402_00000401_00000400);
        next_cycle();
        drive_req(WR_WORD, 32'h0000_0500, 4'hF, 128'h77777777);
        for (int c = 1; c <= 8; c++) begin
            sample();
            check($sformatf("b2b_c%0d_rdy", c), c_wr_rdy, c == 8);
            check($sformatf("b2b_c%0d_done", c), wr_done, c == 8);
            if (c % 2 == 1)
                check_beat($sformatf("b2b_a%0d", c / 2), 32'h400 + 32'(4 * (c / 2)),
                           32'h400 + 32'(c / 2), 4'hF, WR_WORD);
            next_cycle();
        end
        c_wr_req = 1'b0;
        sample(); check_beat("b2b_second", 32'h500, 32'h77777777, 4'hF, WR_WORD); next_cycle();
        sample(); check_gap("b2b_second_done", 1'b1); next_cycle();

        // Reset in the gap after the first beat of a line.
        drive_req(WR_LINE, 32'h0000_0600, 4'h0, 128'h4_00000003_00000002_00000001);
        next_cycle();
        c_wr_req = 1'b0;
        sample(); check_beat("mrst_b0", 32'h600, 32'h1, 4'hF, WR_WORD); next_cycle();
        aresetn = 1'b0;
        next_cycle();
        aresetn = 1'b1;
        sample();
        check("mrst_rdy",   c_wr_rdy,   1'b1);
        check("mrst_addr",  b_wr_addr,  32'h0);
        check("mrst_data",  b_wr_data,  32'h0);
        check("mrst_wstrb", b_wr_wstrb, 4'h0);
        check("mrst_type",  b_wr_type,  3'b000);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) sample();
            check($sformatf("mrst_q%0d_req", c),  b_wr_req, 1'b0);
            check($sformatf("mrst_q%0d_done", c), wr_done,  1'b0);
            next_cycle();
        end

        // Random traffic against a queue of expected beats.
        begin
            beat_t       exp_q[$];
            logic [27:0] cur_line;
            bit          prev_acc;
            bit          done_due;
            bit          busy;
            bit          exp_req;
            bit          exp_haz;
            beat_t       b;
            cur_line = '0;
            prev_acc = 1'b0;
            done_due = 1'b0;
            do_reset();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                c_wr_req = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 3))
                    0:       c_wr_type = WR_BYTE;
                    1:       c_wr_type = WR_HALF;
                    2:       c_wr_type = WR_WORD;
                    default: c_wr_type = WR_LINE;
                endcase
                c_wr_addr  = $urandom;
                c_wr_wstrb = 4'($urandom);
                c_wr_data  = {$urandom, $urandom, $urandom, $urandom};
                b_wr_rdy   = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       rd_chk_addr = {cur_line, 4'($urandom)};
                    1:       rd_chk_addr = {c_wr_addr[31:4], 4'($urandom)};
                    default: rd_chk_addr = $urandom;
                endcase
                sample();
                busy    = (exp_q.size() != 0);
                exp_req = busy && !prev_acc;
                exp_haz = (busy && rd_chk_addr[31:4] == cur_line) ||
                          (!busy && c_wr_req && c_wr_addr[31:4] == rd_chk_addr[31:4]);
                check($sformatf("rnd%0d_req", cyc),  b_wr_req,  exp_req);
                check($sformatf("rnd%0d_rdy", cyc),  c_wr_rdy,  !busy);
                check($sformatf("rnd%0d_done", cyc), wr_done,   done_due);
                check($sformatf("rnd%0d_haz", cyc),  rd_hazard, exp_haz);
                if (exp_req) begin
                    b = exp_q[0];
                    check_beat($sformatf("rnd%0d", cyc), b.addr, b.data, b.wstrb, b.typ);
                end
                if (exp_req && b_wr_rdy) begin
                    void'(exp_q.pop_front());
                    prev_acc = 1'b1;
                    done_due = (exp_q.size() == 0);
                end else begin
                    prev_acc = 1'b0;
                    done_due = 1'b0;
                end
                if (!busy && c_wr_req) begin
                    cur_line = c_wr_addr[31:4];
                    if (c_wr_type == WR_LINE) begin
                        for (int w = 0; w < LW; w++)
                            exp_q.push_back('{addr: {c_wr_addr[31:4], 4'(w * 4)},
                                              data: c_wr_data[32 * w +: 32],
                                              wstrb: 4'hF, typ: WR_WORD});
                    end else begin
                        exp_q.push_back('{addr: c_wr_addr, data: c_wr_data[31:0],
                                          wstrb: c_wr_wstrb, typ: c_wr_type});
                    end
                end
                next_cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcache_wr_serializer.md
# dcache_wr_serializer

Write-side adaptor between the data cache and `AXI_bridge`. It accepts one write request per transaction from the dcache: either a full 128-bit dirty-line write-back or an uncached byte/half/word store. It holds the request in a one-entry buffer and issues it to the bridge's single-beat `dcache_wr_*` port as 32-bit word writes. It also flags read-after-write hazards so the dcache does not issue a refill for a line whose write-back is still draining.

## Interface
Parameters:
- `LINE_WORDS`, 4: words per cache line; must be a power of two. Line offset width is `log2(LINE_WORDS)+2`.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: synchronous reset, active low.
- `c_wr_req` in 1: dcache write request.
- `c_wr_type` in 3: 3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 cache line.
- `c_wr_addr` in 32: byte address of the request. For a line request the offset bits are ignored.
- `c_wr_wstrb` in 4: byte strobes. Used for non-line requests only.
- `c_wr_data` in 128: write data. Word i is `[32i+31:32i]`. A non-line request uses word 0.
- `c_wr_rdy` out 1: request can be accepted this cycle.
- `b_wr_req` out 1: word write request to the bridge.
- `b_wr_type` out 3: type of the current beat. A line beat is 3'b010; otherwise the captured type.
- `b_wr_addr` out 32: address of the current beat.
- `b_wr_wstrb` out 4: strobes of the current beat.
- `b_wr_data` out 32: data of the current beat.
- `b_wr_rdy` in 1: bridge can accept a beat.
- `rd_chk_addr` in 32: address of the dcache read about to be issued.
- `rd_hazard` out 1: `rd_chk_addr` falls in the line being drained.
- `wr_done` out 1: one-cycle pulse when the last beat of a request is accepted.

## Operation
- The request handshake fires on `c_wr_req & c_wr_rdy`. `c_wr_rdy = (state==IDLE)`.
- On capture, the block latches type, address, strobes and all 128 data bits, clears the beat counter `cnt`, and moves IDLE→SEND.
- The beat handshake fires on `b_wr_req & b_wr_rdy`. `b_wr_req = (state==SEND)`.
- Line request:
  - `LINE_WORDS` beats.
  - `b_wr_addr = {addr[31:4], cnt, 2'b00}`.
  - `b_wr_wstrb = 4'hF`.
  - `b_wr_data` = word `cnt`.
  - Beats are issued in ascending word order 0..3, with no wrap from the critical word.
- Non-line request: exactly one beat carrying the captured addr, wstrb and type, with data word 0.
- States:
  - IDLE →SEND on capture.
  - SEND →GAP on a beat handshake that is not the last beat; `cnt` increments.
  - SEND →IDLE on the last-beat handshake.
  - GAP →SEND unconditionally. The one-cycle bubble lets the bridge leave its idle state before the next request is presented.
- `cnt` is 2 bits and only counts to `LINE_WORDS-1`; it never wraps during a transaction.
- `rd_hazard` is combinational and is the OR of two terms:
  - `(state!=IDLE) & (rd_chk_addr[31:4]==buf_addr[31:4])`.
  - A same-cycle capture with `c_wr_addr[31:4]==rd_chk_addr[31:4]`.
- The hazard comparison covers line and non-line requests alike.
- Outputs are held stable while `b_wr_req` is high and `b_wr_rdy` is low.
- `c_wr_req` asserted outside IDLE is ignored. The dcache must hold it until `c_wr_rdy`.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, buffer 0.
  - `c_wr_rdy` = 1, `b_wr_req` = 0, `b_wr_type` = 0, `b_wr_addr` = 0, `b_wr_wstrb` = 0, `b_wr_data` = 0.
  - `wr_done` = 0, `rd_hazard` = 0 while `rd_chk_addr` does not match an incoming capture.
- Capture at cycle T gives the first `b_wr_req` at T+1.
- A beat accepted at cycle A gives the next `b_wr_req` at A+2.
- With `b_wr_rdy` held at 1:
  - A line is accepted at T+1, T+3, T+5 and T+7.
  - `wr_done` is high at T+8 and `c_wr_rdy` returns at T+8.
  - A non-line request gives `wr_done` at T+2.
- `wr_done` is registered: high for exactly the one cycle after the last-beat handshake.
- A new request may be captured in the same cycle `wr_done` is high.
- Reset asserted mid-transaction discards remaining beats with no `wr_done`. Outputs take reset values on the next edge.

## Structure
- Shared package `cache_pkg`:
  - Write-type constants: `WR_BYTE`=3'b000, `WR_HALF`=3'b001, `WR_WORD`=3'b010, `WR_LINE`=3'b100.
  - `LINE_WORDS`.
  - State encoding: IDLE, SEND, GAP, one-hot.
- No sub-module. The block is a single FSM plus a data buffer and a beat mux.

## Test plan
- Line write, `c_wr_addr`=0x1C00_0A38, data words 0x11111111/0x22222222/0x33333333/0x44444444, `b_wr_rdy`=1:
  - Beats go to 0x1C000A30, A34, A38, A3C with matching data, `wstrb` F, `type` 010.
  - Beats fall at T+1/3/5/7 and `wr_done` at T+8.
- Byte store, type 000, addr 0x0000_1003, wstrb 4'b1000, data word0 0xAB000000:
  - One beat with identical addr, strobe, type and data.
  - `wr_done` at T+2.
- `b_wr_rdy` held low for 5 cycles on beat 2:
  - `b_wr_req` and all beat outputs stay constant.
  - Beat 2 is accepted on the first `rdy`, followed by exactly one GAP cycle.
- During a line drain at 0x8000_0040:
  - `rd_chk_addr`=0x8000_004C → `rd_hazard`=1.
  - `rd_chk_addr`=0x8000_0050 → 0.
  - After `wr_done`, 0x8000_004C → 0.
- `c_wr_req` pulsed while in SEND is ignored.
- Back-to-back requests:
  - Second request held from the first cycle; it is captured at the `wr_done` cycle.
  - Its first beat is issued the cycle after capture.
- `aresetn` low for 1 cycle after beat 1 of a line:
  - No further `b_wr_req`, no `wr_done`, `c_wr_rdy`=1 after the reset edge.
